ddr_rd_ctrl: RTL
================

# ddr_rd_ctrl

Read-burst master that sits directly upstream of the line read buffer on `ddr_clk`. It accepts one line-read request at a time (`ddr_rreq`/`ddr_raddr`/`ddr_rd_len`) and splits it into AXI4 read bursts of at most `BURST_MAX` beats. Returned beats are forwarded unthrottled as `ddr_rdata`/`ddr_rdata_en`, and `ddr_rdone` is pulsed once the full line has been received. It bridges the frame/line sequencing logic to the DDR controller's AXI read port.

## Interface
Parameters:
- `ADDR_WIDTH`, 27: address width; unit is one `DQ_WIDTH`-bit word, as on `ddr_raddr`.
- `DQ_WIDTH`, 32: DDR DQ width; data beat is `8*DQ_WIDTH` bits.
- `LEN_WIDTH`, 16: width of `ddr_rd_len` (in beats).
- `BURST_MAX`, 16: maximum beats per AXI burst (1..256).
- `MAX_OUTSTANDING`, 4: maximum AR bursts issued but not yet completed by `rlast`.

Ports:
- `ddr_clk` in 1: single clock.
- `ddr_rst` in 1: asynchronous, active-high reset.
- `ddr_rreq` in 1: request strobe; sampled only while `ddr_rrdy`=1.
- `ddr_raddr` in ADDR_WIDTH: line start address.
- `ddr_rd_len` in LEN_WIDTH: line length in beats.
- `ddr_rrdy` out 1: idle, can accept a request.
- `ddr_rdone` out 1: one-cycle pulse after the last beat of the line.
- `ddr_rdata` out 8*DQ_WIDTH: beat data.
- `ddr_rdata_en` out 1: beat valid.
- `rd_err` out 1: sticky; set on any nonzero `axi_rresp`.
- `axi_araddr` out ADDR_WIDTH, `axi_arlen` out 8, `axi_arvalid` out 1, `axi_arready` in 1: AR channel.
- `axi_rdata` in 8*DQ_WIDTH, `axi_rresp` in 2, `axi_rlast` in 1, `axi_rvalid` in 1, `axi_rready` out 1: R channel.

## Operation
- Reset values: `ddr_rrdy`=1, `ddr_rdone`=0, `ddr_rdata_en`=0, `ddr_rdata`=0, `rd_err`=0, `axi_arvalid`=0, `axi_araddr`=0, `axi_arlen`=0, `axi_rready`=1.
- FSM states:
  - IDLE: `ddr_rrdy`=1. On `ddr_rreq`, capture addr/len, clear the beat counter, go to ADDR. If len=0, go to DONE instead.
  - ADDR: issue bursts in order.
  - WAIT: all AR accepted; wait for the remaining beats.
  - DONE: `ddr_rdone`=1 for exactly one cycle, then IDLE.
- Burst generation:
  - `arlen` = min(remaining_ar, BURST_MAX) − 1.
  - `araddr` advances by (arlen+1)*8 after each AR handshake (`axi_arvalid & axi_arready`).
  - `remaining_ar` decrements by arlen+1; ADDR→WAIT on the handshake that takes it to 0.
  - Address arithmetic is modulo 2^ADDR_WIDTH; wrap is silent.
- Outstanding limit: `axi_arvalid` is held low while outstanding == MAX_OUTSTANDING. Outstanding increments on an AR handshake and decrements on `rvalid & rlast`; simultaneous events leave it unchanged.
- `axi_arvalid`, once high, stays high with `araddr`/`arlen` stable until `axi_arready`.
- R channel:
  - `axi_rready` is constant 1; there is no backpressure.
  - `ddr_rdata_en` = registered `axi_rvalid`; `ddr_rdata` = registered `axi_rdata`.
  - Each beat increments the received count. WAIT→DONE when received == captured len, registered on the last beat.
  - `rresp`≠0 sets `rd_err`. The beat is still forwarded and counted. `rd_err` clears only on reset.
- `ddr_rreq` while `ddr_rrdy`=0 is ignored.
- Reset mid-operation forces IDLE and clears all counters and outputs immediately (async). In-flight AXI beats after reset are the controller's concern.

## Timing
- `ddr_rreq` sampled at edge N → `axi_arvalid`=1 and `ddr_rrdy`=0 from N+1.
- `ddr_rdone` pulses in the cycle after the final `ddr_rdata_en`, i.e. two edges after the final `axi_rvalid` edge.
- `ddr_rrdy` returns to 1 the cycle after `ddr_rdone`.
- Back-to-back ARs are allowed on consecutive cycles when `arready` is held high.
- Data latency is 1 cycle, from `axi_rvalid` to `ddr_rdata_en`.
- len=0: `ddr_rdone` at N+1, `ddr_rrdy` back at N+2, no AR issued.

## Structure
- Shared package holds:
  - FSM state enum {IDLE, ADDR, WAIT, DONE}.
  - AXI response constants (OKAY=2'b00).
  - Beat-to-address scale constant (8 words per beat).
- One sub-module, `ddr_rd_burst_split`: computes arlen and the next address/remaining count from the current address/remaining count. It is purely combinational and instantiated once.

## Test plan
- Request len=180 at addr 0x1000, arready=1, no R stall → 12 ARs: 11×arlen=15, then arlen=3. Addresses 0x1000, 0x1080, …, 0x1580. Exactly 180 `ddr_rdata_en` beats, one `ddr_rdone` pulse.
- arready low for 5 cycles on the 2nd AR → `araddr`/`arlen` held stable. Outstanding never exceeds 4 when R is delayed 40 cycles.
- len=0 → no `axi_arvalid`; `ddr_rdone` at N+1; `ddr_rrdy` high at N+2.
- `ddr_rreq` pulsed while busy → ignored. The following request after `ddr_rrdy` rises completes normally.
- `rresp`=2'b10 on beat 7 → `rd_err`=1 and held. All 180 beats are still forwarded and `ddr_rdone` still pulses.
- `ddr_rst` asserted mid-burst → all outputs at reset values the same cycle. A new request after release completes correctly.

Source files
------------

// File: rtl/ddr_rd_ctrl_pkg.sv
// Shared types and constants for the DDR line-read burst master.
package ddr_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // One data beat spans this many DQ-width address units.
  localparam int unsigned WORDS_PER_BEAT = 8;

endpackage

// File: rtl/ddr_rd_burst_split.sv
// Combinational burst slicer: size of the next AXI burst and where the one after it starts.
module ddr_rd_burst_split
  import ddr_rd_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 27,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned BURST_MAX  = 16
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]  remaining,
  output logic [7:0]            arlen_c,
  output logic [ADDR_WIDTH-1:0] next_addr_c,
  output logic [LEN_WIDTH-1:0]  next_remaining_c
);

  localparam int unsigned STEP_WIDTH = LEN_WIDTH + $clog2(WORDS_PER_BEAT) + 1;
  localparam logic [LEN_WIDTH-1:0] BURST_BEATS = LEN_WIDTH'(BURST_MAX);

  logic [LEN_WIDTH-1:0]  beats;
  logic [STEP_WIDTH-1:0] step;

  // Clamp to BURST_MAX, then advance address (modulo 2^ADDR_WIDTH) and remaining count.
  always_comb begin
    beats            = (remaining > BURST_BEATS) ? BURST_BEATS : remaining;
    arlen_c          = (beats == '0) ? 8'd0 : 8'(beats - LEN_WIDTH'(1));
    step             = STEP_WIDTH'(beats) * STEP_WIDTH'(WORDS_PER_BEAT);
    next_addr_c      = addr + ADDR_WIDTH'(step);
    next_remaining_c = remaining - beats;
  end

endmodule

// File: rtl/ddr_rd_ctrl.sv
// Line-read master: splits one line request into AXI4 read bursts and forwards returned beats.
module ddr_rd_ctrl
  import ddr_rd_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 27,
  parameter int unsigned DQ_WIDTH        = 32,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned BURST_MAX       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    ddr_clk,
  input  logic                    ddr_rst,
  input  logic                    ddr_rreq,
  input  logic [ADDR_WIDTH-1:0]   ddr_raddr,
  input  logic [LEN_WIDTH-1:0]    ddr_rd_len,
  output logic                    ddr_rrdy,
  output logic                    ddr_rdone,
  output logic [8*DQ_WIDTH-1:0]   ddr_rdata,
  output logic                    ddr_rdata_en,
  output logic                    rd_err,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [7:0]              axi_arlen,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [8*DQ_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]              axi_rresp,
  input  logic                    axi_rlast,
  input  logic                    axi_rvalid,
  output logic                    axi_rready
);

  localparam int unsigned DATA_WIDTH = 8 * DQ_WIDTH;
  localparam int unsigned OUT_WIDTH  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_WIDTH-1:0] OUT_LIMIT = OUT_WIDTH'(MAX_OUTSTANDING);

  state_t                 state_q, state_d;
  logic                   rrdy_q, rrdy_d;
  logic                   rdone_q, rdone_d;
  logic                   arvalid_q, arvalid_d;
  logic                   err_q, err_d;
  logic                   rdata_en_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [ADDR_WIDTH-1:0]  araddr_q, araddr_d;
  logic [ADDR_WIDTH-1:0]  next_addr_q, next_addr_d;
  logic [7:0]             arlen_q, arlen_d;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   rcv_q, rcv_d;
  logic [OUT_WIDTH-1:0]   out_q, out_d;

  logic                   ar_hs;
  logic                   r_last;
  logic [ADDR_WIDTH-1:0]  split_addr;
  logic [LEN_WIDTH-1:0]   split_rem;
  logic [7:0]             split_arlen;
  logic [ADDR_WIDTH-1:0]  split_next_addr;
  logic [LEN_WIDTH-1:0]   split_next_rem;

  assign ar_hs  = arvalid_q & axi_arready;
  assign r_last = axi_rvalid & axi_rlast;

  // In IDLE the slicer sees the incoming request; afterwards it sees the burst queued behind the one on AR.
  assign split_addr = (state_q == IDLE) ? ddr_raddr : next_addr_q;
  assign split_rem  = (state_q == IDLE) ? ddr_rd_len : rem_q;

  ddr_rd_burst_split #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .BURST_MAX  (BURST_MAX)
  ) u_split (
    .addr             (split_addr),
    .remaining        (split_rem),
    .arlen_c          (split_arlen),
    .next_addr_c      (split_next_addr),
    .next_remaining_c (split_next_rem)
  );

  // Next-state, AR sequencing, beat and outstanding bookkeeping.
  always_comb begin
    state_d     = state_q;
    rrdy_d      = rrdy_q;
    rdone_d     = 1'b0;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    next_addr_d = next_addr_q;
    rem_d       = rem_q;
    len_d       = len_q;
    rcv_d       = rcv_q;
    err_d       = err_q | (axi_rvalid & (axi_rresp != RESP_OKAY));

    case ({ar_hs, r_last})
      2'b10:   out_d = out_q + OUT_WIDTH'(1);
      2'b01:   out_d = out_q - OUT_WIDTH'(1);
      default: out_d = out_q;
    endcase

    if ((state_q == ADDR || state_q == WAIT) && axi_rvalid) begin
      rcv_d = rcv_q + LEN_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (ddr_rreq) begin
          rrdy_d = 1'b0;
          len_d  = ddr_rd_len;
          rcv_d  = '0;
          if (ddr_rd_len == '0) begin
            state_d = DONE;
            rdone_d = 1'b1;
          end else begin
            state_d     = ADDR;
            arvalid_d   = (out_d < OUT_LIMIT);
            araddr_d    = split_addr;
            arlen_d     = split_arlen;
            next_addr_d = split_next_addr;
            rem_d       = split_next_rem;
          end
        end
      end
      ADDR: begin
        if (ar_hs) begin
          if (rem_q == '0) begin
            state_d   = WAIT;
            arvalid_d = 1'b0;
          end else begin
            arvalid_d   = (out_d < OUT_LIMIT);
            araddr_d    = split_addr;
            arlen_d     = split_arlen;
            next_addr_d = split_next_addr;
            rem_d       = split_next_rem;
          end
        end else if (!arvalid_q) begin
          arvalid_d = (out_d < OUT_LIMIT);
        end
      end
      WAIT: begin
        if (rcv_q == len_q) begin
          state_d = DONE;
          rdone_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        rrdy_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge ddr_clk or posedge ddr_rst) begin
    if (ddr_rst) begin
      state_q     <= IDLE;
      rrdy_q      <= 1'b1;
      rdone_q     <= 1'b0;
      arvalid_q   <= 1'b0;
      err_q       <= 1'b0;
      rdata_en_q  <= 1'b0;
      rdata_q     <= '0;
      araddr_q    <= '0;
      next_addr_q <= '0;
      arlen_q     <= '0;
      rem_q       <= '0;
      len_q       <= '0;
      rcv_q       <= '0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      rrdy_q      <= rrdy_d;
      rdone_q     <= rdone_d;
      arvalid_q   <= arvalid_d;
      err_q       <= err_d;
      rdata_en_q  <= axi_rvalid;
      rdata_q     <= axi_rdata;
      araddr_q    <= araddr_d;
      next_addr_q <= next_addr_d;
      arlen_q     <= arlen_d;
      rem_q       <= rem_d;
      len_q       <= len_d;
      rcv_q       <= rcv_d;
      out_q       <= out_d;
    end
  end

  assign ddr_rrdy     = rrdy_q;
  assign ddr_rdone    = rdone_q;
  assign ddr_rdata    = rdata_q;
  assign ddr_rdata_en = rdata_en_q;
  assign rd_err       = err_q;
  assign axi_araddr   = araddr_q;
  assign axi_arlen    = arlen_q;
  assign axi_arvalid  = arvalid_q;
  assign axi_rready   = 1'b1;

endmodule
